// File: rtl/slave_internal_response_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_slave_package
// Purpose : Shared R-channel response encoding and read-arbiter types.
// Rev     : 1.0  initial release
// ============================================================================
package axi_slave_package;

   // INVALID marks an empty slot on the merged R channel
   typedef enum logic [2:0] {
      OKAY    = 3'd0,
      EXOKAY  = 3'd1,
      SLVERR  = 3'd2,
      DECERR  = 3'd3,
      INVALID = 3'd4
   } resp_t;

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      LOCK_ERR = 2'd1,
      LOCK_CPL = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_ERR = 1'b0,
      SRC_CPL = 1'b1
   } src_t;

   function automatic arb_state_t lock_state(input src_t src);
      return (src == SRC_ERR) ? LOCK_ERR : LOCK_CPL;
   endfunction

endpackage
`default_nettype wire

// File: rtl/slave_internal_response_rd_arbiter_out_slice.sv
`default_nettype none
// ============================================================================
// Module  : rd_resp_out_slice
// Purpose : One-entry register slice driving the merged R channel.
// Rev     : 1.0  initial release
// ============================================================================
module rd_resp_out_slice
   import axi_slave_package::*;
#(
   parameter int ID_W   = 4,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              ld_rlast,
   input  logic [ID_W-1:0]   ld_rid,
   input  logic [DATA_W-1:0] ld_rdata,
   input  resp_t             ld_rresp,
   input  logic              ready,
   output logic              can_load,
   output logic              valid,
   output logic              rlast,
   output logic [ID_W-1:0]   rid,
   output logic [DATA_W-1:0] rdata,
   output resp_t             rresp
);

   logic              r_valid;
   logic              r_rlast;
   logic [ID_W-1:0]   r_rid;
   logic [DATA_W-1:0] r_rdata;
   resp_t             r_rresp;

   assign can_load = !r_valid || ready;

   // Draining without refill returns the payload to its idle encoding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_rlast <= 1'b0;
         r_rid   <= '0;
         r_rdata <= '0;
         r_rresp <= INVALID;
      end else if (load) begin
         r_valid <= 1'b1;
         r_rlast <= ld_rlast;
         r_rid   <= ld_rid;
         r_rdata <= ld_rdata;
         r_rresp <= ld_rresp;
      end else if (ready) begin
         r_valid <= 1'b0;
         r_rlast <= 1'b0;
         r_rid   <= '0;
         r_rdata <= '0;
         r_rresp <= INVALID;
      end
   end

   assign valid = r_valid;
   assign rlast = r_rlast;
   assign rid   = r_rid;
   assign rdata = r_rdata;
   assign rresp = r_rresp;

endmodule
`default_nettype wire

// File: rtl/slave_internal_response_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : slave_internal_response_rd_arbiter
// Purpose : Burst-locked round-robin merge of error and completion R beats.
// Rev     : 1.0  initial release
// ============================================================================
module slave_internal_response_rd_arbiter
   import axi_slave_package::*;
#(
   parameter int ID_W      = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 256
)(
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              err_RVALID,
   input  logic              err_RLAST,
   input  logic [ID_W-1:0]   err_RID,
   input  logic [DATA_W-1:0] err_RDATA,
   input  resp_t             err_RRESP,
   output logic              err_RREADY,
   input  logic              cpl_RVALID,
   input  logic              cpl_RLAST,
   input  logic [ID_W-1:0]   cpl_RID,
   input  logic [DATA_W-1:0] cpl_RDATA,
   input  resp_t             cpl_RRESP,
   output logic              cpl_RREADY,
   output logic              out_RVALID,
   output logic              out_RLAST,
   output logic [ID_W-1:0]   out_RID,
   output logic [DATA_W-1:0] out_RDATA,
   output resp_t             out_RRESP,
   input  logic              out_RREADY,
   output logic              burst_overrun
);

   localparam int                 c_cnt_w     = $clog2(MAX_BEATS) + 1;
   localparam logic [c_cnt_w-1:0] c_max_beats = c_cnt_w'(MAX_BEATS);

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   src_t                r_rr_last;
   src_t                w_rr_last_next;
   logic [c_cnt_w-1:0]  r_beat_cnt;
   logic [c_cnt_w-1:0]  w_beat_cnt_next;
   logic [c_cnt_w-1:0]  w_cnt_inc;
   logic                r_overrun;

   src_t                w_grant;
   logic                w_grant_vld;
   logic                w_can_load;
   logic                w_accept;
   logic                w_sel_last;
   logic [ID_W-1:0]     w_sel_rid;
   logic [DATA_W-1:0]   w_sel_rdata;
   resp_t               w_sel_rresp;
   logic                w_overrun;
   logic                w_out_last;

   // A lock serves only its owner; ARB alternates on ties away from rr_last
   always_comb begin
      w_grant     = SRC_ERR;
      w_grant_vld = 1'b0;
      case (r_state)
         ARB: begin
            w_grant_vld = err_RVALID || cpl_RVALID;
            if (err_RVALID && cpl_RVALID)
               w_grant = (r_rr_last == SRC_ERR) ? SRC_CPL : SRC_ERR;
            else if (cpl_RVALID)
               w_grant = SRC_CPL;
            else
               w_grant = SRC_ERR;
         end
         LOCK_ERR: begin
            w_grant     = SRC_ERR;
            w_grant_vld = err_RVALID;
         end
         LOCK_CPL: begin
            w_grant     = SRC_CPL;
            w_grant_vld = cpl_RVALID;
         end
         default: begin
            w_grant     = SRC_ERR;
            w_grant_vld = 1'b0;
         end
      endcase
   end

   assign w_accept   = w_grant_vld && w_can_load;
   assign err_RREADY = w_grant_vld && (w_grant == SRC_ERR) && w_can_load;
   assign cpl_RREADY = w_grant_vld && (w_grant == SRC_CPL) && w_can_load;

   assign w_sel_last  = (w_grant == SRC_CPL) ? cpl_RLAST : err_RLAST;
   assign w_sel_rid   = (w_grant == SRC_CPL) ? cpl_RID   : err_RID;
   assign w_sel_rdata = (w_grant == SRC_CPL) ? cpl_RDATA : err_RDATA;
   assign w_sel_rresp = (w_grant == SRC_CPL) ? cpl_RRESP : err_RRESP;

   // Beat MAX_BEATS without RLAST is truncated into a last beat
   assign w_cnt_inc  = r_beat_cnt + c_cnt_w'(1);
   assign w_overrun  = w_accept && !w_sel_last && (w_cnt_inc == c_max_beats);
   assign w_out_last = w_sel_last || w_overrun;

   always_comb begin
      w_state_next    = r_state;
      w_rr_last_next  = r_rr_last;
      w_beat_cnt_next = r_beat_cnt;
      if (w_accept) begin
         if (w_out_last) begin
            w_state_next    = ARB;
            w_rr_last_next  = w_grant;
            w_beat_cnt_next = '0;
         end else begin
            w_state_next    = lock_state(w_grant);
            w_beat_cnt_next = w_cnt_inc;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state    <= ARB;
         r_rr_last  <= SRC_ERR;
         r_beat_cnt <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_rr_last  <= w_rr_last_next;
         r_beat_cnt <= w_beat_cnt_next;
         r_overrun  <= w_overrun;
      end
   end

   assign burst_overrun = r_overrun;

   rd_resp_out_slice #(
      .ID_W   (ID_W),
      .DATA_W (DATA_W)
   ) u_out_slice (
      .clk      (ACLK),
      .rst_n    (ARESETn),
      .load     (w_accept),
      .ld_rlast (w_out_last),
      .ld_rid   (w_sel_rid),
      .ld_rdata (w_sel_rdata),
      .ld_rresp (w_sel_rresp),
      .ready    (out_RREADY),
      .can_load (w_can_load),
      .valid    (out_RVALID),
      .rlast    (out_RLAST),
      .rid      (out_RID),
      .rdata    (out_RDATA),
      .rresp    (out_RRESP)
   );

endmodule
`default_nettype wire

// File: doc/slave_internal_response_rd_arbiter.md
SLAVE_INTERNAL_RESPONSE_RD_ARBITER -- requirements
Module: slave_internal_response_rd_arbiter

Interface
REQ-001 SHALL have parameter ID_W, default 4, RID width.
REQ-002 SHALL have parameter DATA_W, default 32, RDATA width.
REQ-003 SHALL have parameter MAX_BEATS, default 256, longest legal burst in beats.
REQ-004 Clock and reset SHALL be fixed as: one clock; reset is asynchronous and active-low.
REQ-005 Clock port: ACLK  in  1  sole clock, rising edge.
REQ-006 Reset port: ARESETn  in  1  asynchronous active-low reset.
REQ-007 err_RVALID / err_RLAST  in  1 each  error-source beat valid / last beat.
REQ-008 err_RID / err_RDATA / err_RRESP  in  ID_W / DATA_W / resp_t  error-source beat payload.
REQ-009 err_RREADY  out  1  error-source beat accepted.
REQ-010 cpl_RVALID, cpl_RLAST, cpl_RID, cpl_RDATA, cpl_RRESP, cpl_RREADY SHALL be the completion-source set, with the same directions and widths as err_*.
REQ-011 out_RVALID / out_RLAST  out  1 each  merged beat valid / last beat.
REQ-012 out_RID / out_RDATA / out_RRESP  out  ID_W / DATA_W / resp_t  merged beat payload.
REQ-013 out_RREADY  in  1  downstream R-channel ready.
REQ-014 burst_overrun  out  1  one-cycle pulse when a burst is truncated.

Function
REQ-015 The FSM SHALL have three states: ARB (no burst open), LOCK_ERR and LOCK_CPL.
REQ-016 The output SHALL be a one-entry register slice; it can load when it is empty or when out_RREADY=1 in the same cycle.
REQ-017 In ARB, the grant SHALL go to the single valid source when only one is valid.
REQ-018 In ARB with both sources valid, the grant SHALL go to the source not equal to rr_last.
REQ-019 rr_last SHALL reset to ERR, so the completion source wins the first tie.
REQ-020 Granted src_RREADY SHALL equal "slice can load".
REQ-021 Non-granted src_RREADY SHALL be 0.
REQ-022 An accepted beat SHALL appear on out_* on the next cycle, giving one cycle of latency and one beat per cycle of throughput.
REQ-023 An accepted beat with RLAST=0 in ARB SHALL move the FSM to LOCK_<src>.
REQ-024 An accepted beat with RLAST=1 in ARB SHALL keep the FSM in ARB and set rr_last to <src>.
REQ-025 In LOCK_x, only source x SHALL be served, regardless of the other source's RVALID.
REQ-026 In LOCK_x, an accepted beat with RLAST=1 SHALL return the FSM to ARB and set rr_last to x.
REQ-027 A beat counter (width clog2(MAX_BEATS)+1) SHALL increment on each accepted beat and clear on any accepted last beat.
REQ-028 When an accepted beat is beat number MAX_BEATS and has RLAST=0, out_RLAST SHALL be forced to 1, burst_overrun SHALL pulse, and the FSM SHALL return to ARB.
REQ-029 While out_RVALID=1 and out_RREADY=0, all out_* SHALL hold stable.
REQ-030 While out_RVALID=0, out_RRESP SHALL be INVALID and out_RID, out_RDATA and out_RLAST SHALL be 0.
REQ-031 When a source drops RVALID mid-burst, the lock SHALL be held with no timeout.

Reset
REQ-032 On ARESETn=0, the FSM SHALL go to ARB, rr_last to ERR and the beat counter to 0.
REQ-033 On ARESETn=0, out_RVALID and burst_overrun SHALL go to 0, out_RRESP to INVALID, and all other outputs to 0.
REQ-034 A reset mid-burst SHALL discard the slice contents and the open burst.
REQ-035 The first post-reset grant SHALL follow REQ-017 to REQ-019.

Structure
REQ-036 resp_t (including INVALID) and the arbiter state enum SHALL live in axi_slave_package.
REQ-037 The output slice SHALL be the sub-module rd_resp_out_slice.
REQ-038 The arbiter FSM, round-robin pointer and beat counter SHALL remain in the top module.

Verification
REQ-039 Single error beat: err RID=3, RRESP=SLVERR, RLAST=1, out_RREADY=1 -> out_RVALID high the next cycle with RID=3 and SLVERR; err_RREADY high for exactly one cycle.
REQ-040 Tie after reset: both sources send single beats, RID 1 (err) and RID 2 (cpl), on the same cycle -> output order RID 2 then RID 1.
REQ-041 Burst lock: cpl sends a 4-beat burst while err is valid from beat 2 -> 4 cpl beats are output contiguously, then the err beat; err_RREADY stays 0 during the burst.
REQ-042 Backpressure: out_RREADY=0 for 5 cycles with a beat loaded -> out_* stable throughout; src_RREADY=0 once the slice is full.
REQ-043 Overrun: MAX_BEATS=4 and cpl sends 6 beats with no RLAST -> beat 4 is output with RLAST=1 and burst_overrun pulses once; the FSM returns to ARB.
REQ-044 Reset mid-burst: ARESETn asserted after beat 2 of 4 -> out_RVALID=0 and out_RRESP=INVALID immediately; the next tie goes to cpl.
